// File: rtl/microstep_sequencer_pkg.sv
// +----------------------------------------------------------------------------+
// | Package : microstep_sequencer_pkg                                          |
// | Purpose : Shared widths, FSM state encoding and step-size helper for the   |
// |           microstep sequencer and its cosine lookup table.                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package microstep_sequencer_pkg;

  localparam int PHASE_W   = 8;  // electrical phase: 4 quadrants x 64 entries
  localparam int IDX_W     = 6;  // quarter-wave table index
  localparam int MAG_W     = 8;  // coil magnitude
  localparam int MSRES_MAX = 6;  // largest shift; one full step

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOK_A = 2'd1,
    ST_LOOK_B = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Phase increment for a microstep resolution; codes above the full-step
  // shift saturate to a full step.
  function automatic logic [PHASE_W-1:0] step_size(input logic [2:0] ms);
    logic [2:0] sh;
    sh = (ms > 3'(MSRES_MAX)) ? 3'(MSRES_MAX) : ms;
    return PHASE_W'(1) << sh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/microstep_sequencer_cosine.sv
// +----------------------------------------------------------------------------+
// | Module  : microstep_sequencer_cosine                                       |
// | Purpose : Combinational quarter-wave cosine table,                         |
// |           o_mag = round(255 * cos(i_idx * pi / 128)).                      |
// | Ports   : i_idx [5:0] table index                                          |
// |           o_mag [7:0] magnitude                                            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module microstep_sequencer_cosine
  import microstep_sequencer_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  output logic [MAG_W-1:0] o_mag
);

  always_comb begin
    o_mag = '0;
    case (i_idx)
      6'd0:  o_mag = 8'd255; 6'd1:  o_mag = 8'd255; 6'd2:  o_mag = 8'd255; 6'd3:  o_mag = 8'd254;
      6'd4:  o_mag = 8'd254; 6'd5:  o_mag = 8'd253; 6'd6:  o_mag = 8'd252; 6'd7:  o_mag = 8'd251;
      6'd8:  o_mag = 8'd250; 6'd9:  o_mag = 8'd249; 6'd10: o_mag = 8'd247; 6'd11: o_mag = 8'd246;
      6'd12: o_mag = 8'd244; 6'd13: o_mag = 8'd242; 6'd14: o_mag = 8'd240; 6'd15: o_mag = 8'd238;
      6'd16: o_mag = 8'd236; 6'd17: o_mag = 8'd233; 6'd18: o_mag = 8'd231; 6'd19: o_mag = 8'd228;
      6'd20: o_mag = 8'd225; 6'd21: o_mag = 8'd222; 6'd22: o_mag = 8'd219; 6'd23: o_mag = 8'd215;
      6'd24: o_mag = 8'd212; 6'd25: o_mag = 8'd208; 6'd26: o_mag = 8'd205; 6'd27: o_mag = 8'd201;
      6'd28: o_mag = 8'd197; 6'd29: o_mag = 8'd193; 6'd30: o_mag = 8'd189; 6'd31: o_mag = 8'd185;
      6'd32: o_mag = 8'd180; 6'd33: o_mag = 8'd176; 6'd34: o_mag = 8'd171; 6'd35: o_mag = 8'd167;
      6'd36: o_mag = 8'd162; 6'd37: o_mag = 8'd157; 6'd38: o_mag = 8'd152; 6'd39: o_mag = 8'd147;
      6'd40: o_mag = 8'd142; 6'd41: o_mag = 8'd136; 6'd42: o_mag = 8'd131; 6'd43: o_mag = 8'd126;
      6'd44: o_mag = 8'd120; 6'd45: o_mag = 8'd115; 6'd46: o_mag = 8'd109; 6'd47: o_mag = 8'd103;
      6'd48: o_mag = 8'd98;  6'd49: o_mag = 8'd92;  6'd50: o_mag = 8'd86;  6'd51: o_mag = 8'd80;
      6'd52: o_mag = 8'd74;  6'd53: o_mag = 8'd68;  6'd54: o_mag = 8'd62;  6'd55: o_mag = 8'd56;
      6'd56: o_mag = 8'd50;  6'd57: o_mag = 8'd44;  6'd58: o_mag = 8'd37;  6'd59: o_mag = 8'd31;
      6'd60: o_mag = 8'd25;  6'd61: o_mag = 8'd19;  6'd62: o_mag = 8'd13;  6'd63: o_mag = 8'd6;
      default: o_mag = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/microstep_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module  : microstep_sequencer                                              |
// | Purpose : Step/direction to two-coil signed microstep current setpoints.   |
// |           One cosine table is time-shared between coil A and coil B.       |
// | Ports   : clk, resetn (async, active low)                                  |
// |           enable  drive enable, low zeroes the outputs and blocks steps    |
// |           step    step request (rising edge), dir 1 = phase increments     |
// |           msres   step size 1<<msres phase counts (7 behaves as 6)         |
// |           phase   electrical phase                                         |
// |           a_mag/a_neg, b_mag/b_neg  coil magnitude and polarity            |
// |           valid   one-cycle pulse on output update, busy = FSM not idle    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module microstep_sequencer
  import microstep_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               step,
  input  logic               dir,
  input  logic [2:0]         msres,
  output logic [PHASE_W-1:0] phase,
  output logic [MAG_W-1:0]   a_mag,
  output logic [MAG_W-1:0]   b_mag,
  output logic               a_neg,
  output logic               b_neg,
  output logic               valid,
  output logic               busy
);

  state_t             r_state;
  logic               r_step_q;
  logic               r_en_q;
  logic [PHASE_W-1:0] r_phase;
  logic [MAG_W-1:0]   r_a_tmp;
  logic [MAG_W-1:0]   r_b_tmp;
  logic [1:0]         r_q;       // quadrant the A lookup was made for
  logic [MAG_W-1:0]   r_a_mag;
  logic [MAG_W-1:0]   r_b_mag;
  logic               r_a_neg;
  logic               r_b_neg;
  logic               r_valid;

  logic               w_edge;
  logic               w_en_rise;
  logic [1:0]         w_q;
  logic [IDX_W-1:0]   w_i;
  logic [IDX_W-1:0]   w_a_idx;
  logic [IDX_W-1:0]   w_b_idx;
  logic [IDX_W-1:0]   w_idx;
  logic [MAG_W-1:0]   w_mag;
  logic [PHASE_W-1:0] w_step_sz;
  logic [PHASE_W-1:0] w_phase_nxt;

  assign w_edge    = step & ~r_step_q & enable;
  assign w_en_rise = enable & ~r_en_q;

  assign w_q = r_phase[PHASE_W-1:IDX_W];
  assign w_i = r_phase[IDX_W-1:0];

  // Odd quadrants run the quarter wave backwards; B is A shifted 90 degrees.
  assign w_a_idx = w_q[0] ? ~w_i : w_i;
  assign w_b_idx = w_q[0] ? w_i  : ~w_i;
  assign w_idx   = (r_state == ST_LOOK_B) ? w_b_idx : w_a_idx;

  assign w_step_sz   = step_size(msres);
  assign w_phase_nxt = dir ? (r_phase + w_step_sz) : (r_phase - w_step_sz);

  microstep_sequencer_cosine u_cosine (
    .i_idx (w_idx),
    .o_mag (w_mag)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_step_q <= 1'b0;
      r_en_q   <= 1'b0;
      r_phase  <= '0;
      r_a_tmp  <= '0;
      r_b_tmp  <= '0;
      r_q      <= '0;
      r_a_mag  <= '0;
      r_b_mag  <= '0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_step_q <= step;
      r_en_q   <= enable;
      r_valid  <= 1'b0;
      if (!enable) begin
        r_state <= ST_IDLE;
        r_a_mag <= '0;
        r_b_mag <= '0;
        r_a_neg <= 1'b0;
        r_b_neg <= 1'b0;
      end else begin
        if (w_edge) begin
          r_phase <= w_phase_nxt;
        end
        case (r_state)
          ST_IDLE: begin
            if (w_edge || w_en_rise) begin
              r_state <= ST_LOOK_A;
            end
          end
          ST_LOOK_A: begin
            // A new edge makes this lookup stale: restart on the new phase.
            if (w_edge) begin
              r_state <= ST_LOOK_A;
            end else begin
              r_a_tmp <= w_mag;
              r_q     <= w_q;
              r_state <= ST_LOOK_B;
            end
          end
          ST_LOOK_B: begin
            if (w_edge) begin
              r_state <= ST_LOOK_A;
            end else begin
              r_b_tmp <= w_mag;
              r_state <= ST_COMMIT;
            end
          end
          ST_COMMIT: begin
            r_a_mag <= r_a_tmp;
            r_b_mag <= r_b_tmp;
            r_a_neg <= (r_q == 2'd1) || (r_q == 2'd2);
            r_b_neg <= r_q[1];
            r_valid <= 1'b1;
            r_state <= w_edge ? ST_LOOK_A : ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign phase = r_phase;
  assign a_mag = r_a_mag;
  assign b_mag = r_b_mag;
  assign a_neg = r_a_neg;
  assign b_neg = r_b_neg;
  assign valid = r_valid;
  assign busy  = (r_state != ST_IDLE);

endmodule

`default_nettype wire
